seq_check_2b: RTL and testbench
===============================

// Module: seq_check_2b
// PURPOSE
//  - Serial pattern detector: consumes 2 stream bits per clock on data_in; data_in[1] is the earlier bit in time.
//  - Flags every occurrence of the 7-bit pattern 1011001, overlapping matches included.
//  - Front-end monitor on a 2-bit-wide serial link; flag_out feeds event counters and interrupt logic.
// PARAMETERS
//  - PATTERN  7'b1011001  pattern to detect; MSB is the first bit in time.
//  - PAT_LEN  7           pattern length in bits; legal range 2..15.
// PORTS
//  - clk       in   1  single clock; all state updates on the rising edge.
//  - rst_n     in   1  reset; synchronous and active-high (rst_n=1 resets on the next rising clk edge).
//  - data_in   in   2  two stream bits per cycle; [1] first, [0] second.
//  - flag_out  out  1  registered match flag; 1-cycle pulse per cycle containing a match.
//  - match_cnt out  16 only with SEQ_CHECK_CNT_EN; match counter.
// BEHAVIOUR
//  - Reset: flag_out=0, bit history cleared, fill counter=0, match_cnt=0. Reset wins over all other updates.
//  - Each cycle out of reset, the stream advances by 2 bits.
//  - Match window: w = {hist[PAT_LEN-2:0], data_in[1], data_in[0]}, width PAT_LEN+1.
//    - m1 (pattern ends at bit [1]): w[PAT_LEN:1]==PATTERN.
//    - m0 (pattern ends at bit [0]): w[PAT_LEN-1:0]==PATTERN.
//  - History update: hist <= w[PAT_LEN-2:0]. hist holds the last PAT_LEN-1 stream bits.
//  - Fill qualification: counter fill counts received bits, saturating at PAT_LEN.
//    - m1 is valid only if fill+1 >= PAT_LEN.
//    - m0 is valid only if fill+2 >= PAT_LEN.
//    - So bits present before reset, and the zero prefill, never produce a match.
//  - Flag: flag_out <= (m1 & valid) | (m0 & valid).
//    - Latency: asserted in the cycle after the edge that sampled the completing symbol.
//    - Deasserted next cycle unless a new match occurs.
//  - Overlap: a match may reuse bits of the previous match; no internal state is reset after a hit.
//  - Both m1 and m0 in one cycle: flag_out=1 (single pulse); match_cnt adds 2.
//    - Cannot occur for 1011001, but is required for generic PATTERN.
//  - Reset asserted mid-stream: any partial match is discarded. Detection restarts from an empty history.
//  - No X-propagation requirements on data_in beyond standard synthesis semantics.
// CONFIGURATION
//  - Macro SEQ_CHECK_CNT_EN, when defined:
//    - Adds output match_cnt[15:0], cleared by reset.
//    - Increments by m1+m0 (valid matches) each cycle; saturates at 16'hFFFF.
//    - Updated on the same edge as flag_out.
//  - When undefined: no match_cnt port or counter logic; flag_out behaviour is identical.
// STRUCTURE
//  - Package seq_check_pkg:
//    - localparam SEQ_PATTERN=7'b1011001, SEQ_LEN=7.
//    - function pat_match(window, pattern) returning 1 bit.
//  - Sub-module seq_window_cmp: combinational comparator.
//    - Inputs: PAT_LEN+1-bit window plus fill.
//    - Outputs: qualified m1/m0.
//    - Instantiated once.
//  - Top level: history register, fill counter, flag register, optional counter.
// TESTING
//  - Stimulus: reset 2 cycles, then symbols 10,11,00,11 -> flag_out=1 exactly in the cycle after 11 (4th symbol) is sampled; 0 before.
//  - Continue with 10,11,00,10,11,00,11 (stream 1011001110110010110011):
//    - Flag pulses follow symbol 8 (10) and symbol 11 (11), proving overlap.
//    - Total 3 pulses; match_cnt=3 with SEQ_CHECK_CNT_EN.
//  - Pattern split across symbol boundary (symbols 01,01,10,01 = stream 01011001) -> one pulse after 4th symbol (m0 path).
//  - All-zero input for 50 cycles after reset -> flag_out stays 0; match_cnt stays 0.
//  - Assert rst_n=1 after symbols 10,11,00, then resume with 11 -> no pulse; history was cleared by reset.
//  - 100 random symbols vs bit-serial reference model -> flag_out matches cycle-by-cycle; with the macro, match_cnt equals the model count.

Source files
------------

// File: rtl/seq_check_pkg.sv
// ============================================================================
// Module      : seq_check_pkg
// Description : Shared constants and window-compare helper for the 2-bit/cycle
//               serial pattern detector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_check_pkg;

    localparam logic [6:0] SEQ_PATTERN = 7'b1011001;
    localparam int         SEQ_LEN     = 7;
    localparam int         MAX_LEN     = 15;
    localparam int         WIN_W       = MAX_LEN + 1;

    // Operands are zero-extended to the widest legal pattern by the caller.
    function automatic logic pat_match(input logic [WIN_W-1:0] window,
                                       input logic [WIN_W-1:0] pattern);
        return window == pattern;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_check_2b_if.sv
// ============================================================================
// Module      : seq_check_2b_if
// Description : Stream/flag bundle of the pattern detector. match_cnt exists
//               only when SEQ_CHECK_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_check_2b_if;

    logic [1:0]  data_in;
    logic        flag_out;
`ifdef SEQ_CHECK_CNT_EN
    logic [15:0] match_cnt;

    modport master (output data_in, input  flag_out, input  match_cnt);
    modport slave  (input  data_in, output flag_out, output match_cnt);
`else
    modport master (output data_in, input  flag_out);
    modport slave  (input  data_in, output flag_out);
`endif

endinterface

`default_nettype wire

// File: rtl/seq_window_cmp.sv
// ============================================================================
// Module      : seq_window_cmp
// Description : Combinational comparator for the two pattern end positions in
//               the current window, qualified by the history fill level.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_window_cmp
    import seq_check_pkg::*;
#(
    parameter int                 PAT_LEN = SEQ_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = SEQ_PATTERN,
    parameter int                 FILL_W  = 4
) (
    input  wire logic [PAT_LEN:0]  i_window,
    input  wire logic [FILL_W-1:0] i_fill,
    output logic                   o_m1,
    output logic                   o_m0
);

    logic w_eq1;
    logic w_eq0;
    logic w_ok1;
    logic w_ok0;

    assign w_eq1 = pat_match(WIN_W'(i_window[PAT_LEN:1]),   WIN_W'(PATTERN));
    assign w_eq0 = pat_match(WIN_W'(i_window[PAT_LEN-1:0]), WIN_W'(PATTERN));

    // A match only counts once every bit it covers arrived after reset.
    assign w_ok1 = (i_fill + FILL_W'(1)) >= FILL_W'(PAT_LEN);
    assign w_ok0 = (i_fill + FILL_W'(2)) >= FILL_W'(PAT_LEN);

    assign o_m1 = w_eq1 & w_ok1;
    assign o_m0 = w_eq0 & w_ok0;

endmodule

`default_nettype wire

// File: rtl/seq_check_2b.sv
// ============================================================================
// Module      : seq_check_2b
// Description : Overlapping serial pattern detector taking two stream bits per
//               clock. Optional saturating match counter via SEQ_CHECK_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_check_2b
    import seq_check_pkg::*;
#(
    parameter int                 PAT_LEN = SEQ_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = SEQ_PATTERN
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    seq_check_2b_if.slave  bus
);

    // Wide enough to hold fill+2 without wrapping.
    localparam int FILL_W = $clog2(PAT_LEN + 3);

    logic [PAT_LEN-2:0] r_hist;
    logic [FILL_W-1:0]  r_fill;
    logic               r_flag;

    logic [PAT_LEN:0]   w_window;
    logic [FILL_W-1:0]  w_fill_sum;
    logic [FILL_W-1:0]  w_fill_next;
    logic               w_m1;
    logic               w_m0;

    assign w_window    = {r_hist, bus.data_in};
    assign w_fill_sum  = r_fill + FILL_W'(2);
    assign w_fill_next = (w_fill_sum >= FILL_W'(PAT_LEN)) ? FILL_W'(PAT_LEN) : w_fill_sum;

    seq_window_cmp #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN),
        .FILL_W  (FILL_W)
    ) u_cmp (
        .i_window (w_window),
        .i_fill   (r_fill),
        .o_m1     (w_m1),
        .o_m0     (w_m0)
    );

    // rst_n is active-high despite its name.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_hist <= '0;
            r_fill <= '0;
            r_flag <= 1'b0;
        end else begin
            r_hist <= w_window[PAT_LEN-2:0];
            r_fill <= w_fill_next;
            r_flag <= w_m1 | w_m0;
        end
    end

    assign bus.flag_out = r_flag;

`ifdef SEQ_CHECK_CNT_EN
    logic [15:0] r_cnt;
    logic [16:0] w_cnt_sum;

    assign w_cnt_sum = {1'b0, r_cnt} + 17'(w_m1) + 17'(w_m0);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
        end
    end

    assign bus.match_cnt = r_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_check_2b.sv
// ============================================================================
// Module      : tb_seq_check_2b
// Description : Directed and random checks of seq_check_2b against a
//               bit-stream reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_check_2b;
    import seq_check_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    seq_check_2b_if bus ();

    seq_check_2b #(
        .PAT_LEN (SEQ_LEN),
        .PATTERN (SEQ_PATTERN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int model_cnt = 0;
    int dut_pulses = 0;
    bit stream[$];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // 1 if a full pattern ends at stream position e (0 = first bit since reset).
    function automatic int match_at(input int e);
        logic [SEQ_LEN-1:0] pat;
        pat = SEQ_PATTERN;
        if (e + 1 < SEQ_LEN) return 0;
        for (int k = 0; k < SEQ_LEN; k++)
            if (stream[e - SEQ_LEN + 1 + k] != pat[SEQ_LEN - 1 - k]) return 0;
        return 1;
    endfunction

    task automatic apply(input logic r, input logic [1:0] sym, input string tag);
        int  hits;
        logic exp_flag;
        @(negedge clk);
        rst_n       = r;
        bus.data_in = sym;
        @(posedge clk);
        #1;
        exp_flag = 1'b0;
        if (r) begin
            stream.delete();
            model_cnt = 0;
        end else begin
            stream.push_back(sym[1]);
            stream.push_back(sym[0]);
            hits = match_at(stream.size() - 2) + match_at(stream.size() - 1);
            exp_flag = (hits != 0);
            model_cnt = (model_cnt + hits > 65535) ? 65535 : model_cnt + hits;
        end
        check(tag, 16'(bus.flag_out), 16'(exp_flag));
`ifdef SEQ_CHECK_CNT_EN
        check({tag, "_cnt"}, bus.match_cnt, 16'(model_cnt));
`endif
        if (bus.flag_out === 1'b1) dut_pulses++;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) apply(1'b1, 2'b00, "reset");
        dut_pulses = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] seq1 [11] = '{2'b10, 2'b11, 2'b00, 2'b11, 2'b10, 2'b11,
                                  2'b00, 2'b10, 2'b11, 2'b00, 2'b11};
        logic [1:0] seq2 [4]  = '{2'b01, 2'b01, 2'b10, 2'b01};
        rst_n       = 1'b1;
        bus.data_in = 2'b00;

        // Basic detection and overlap
        do_reset(2);
        check("reset_flag", 16'(bus.flag_out), 16'd0);
        for (int i = 0; i < 4; i++) apply(1'b0, seq1[i], "seq1");
        check("seq1_first_hit", 16'(bus.flag_out), 16'd1);
        check("seq1_pulses4", 16'(dut_pulses), 16'd1);
        for (int i = 4; i < 11; i++) apply(1'b0, seq1[i], "seq1");
        check("seq1_pulses", 16'(dut_pulses), 16'd3);
`ifdef SEQ_CHECK_CNT_EN
        check("seq1_cnt_total", bus.match_cnt, 16'd3);
`endif

        // Pattern ending on the second bit of a symbol
        do_reset(1);
        for (int i = 0; i < 4; i++) apply(1'b0, seq2[i], "split");
        check("split_hit", 16'(bus.flag_out), 16'd1);
        check("split_pulses", 16'(dut_pulses), 16'd1);

        // Idle all-zero stream
        do_reset(1);
        for (int i = 0; i < 50; i++) apply(1'b0, 2'b00, "zeros");
        check("zeros_pulses", 16'(dut_pulses), 16'd0);

        // Reset mid-pattern discards the partial match
        do_reset(1);
        for (int i = 0; i < 3; i++) apply(1'b0, seq1[i], "midrst");
        apply(1'b1, 2'b00, "midrst_rst");
        apply(1'b0, 2'b11, "midrst_resume");
        check("midrst_pulses", 16'(dut_pulses), 16'd0);

        // Random stream
        do_reset(1);
        for (int i = 0; i < 100; i++) apply(1'b0, 2'($urandom_range(0, 3)), "rand");
        // Biased stream repeating the pattern to exercise back-to-back hits
        for (int i = 0; i < 40; i++)
            apply(1'b0, ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : seq1[i % 11], "rand_bias");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
